// File: rtl/teclas_pkg.sv
// teclas_pkg: shared constants and helpers for the pushbutton input stage.
//   - Key index constants (bit positions in KEY / keysout).
//   - Default timing constants for a 50 MHz clock.
//   - Debounced key state encoding.
//   - largura(): number of bits needed to hold a given maximum count.
package teclas_pkg;

    localparam int unsigned TECLA_DIR       = 0;
    localparam int unsigned TECLA_ESQ       = 1;
    localparam int unsigned TECLA_PAUSA     = 2;
    localparam int unsigned TECLA_REINICIO  = 3;

    localparam int unsigned DEBOUNCE_PADRAO = 500000;    // 10 ms at 50 MHz
    localparam int unsigned TICK_PADRAO     = 250000;    // 5 ms repeat period
    localparam int unsigned ACCEL_PADRAO    = 25000000;  // 0.5 s hold before speed-up

    typedef enum logic {
        SOLTA       = 1'b0,
        PRESSIONADA = 1'b1
    } estado_tecla_t;

    // Bits required to represent values 0..maximo (at least 1).
    function automatic int unsigned largura(input int unsigned maximo);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((maximo >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_tecla.sv
// debounce_tecla: single pushbutton conditioner.
//   Two-flop synchroniser, counter-based debouncer and rising-edge detector.
// Ports:
//   CLOCK_50   - system clock
//   reset      - asynchronous active-low reset
//   key_n      - raw pushbutton, active-low
//   nivel      - debounced level the stable state holds after the coming edge
//   pressionou - high on the cycle whose edge moves the stable state to pressed
module debounce_tecla
    import teclas_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic nivel,
    output logic pressionou
);

    localparam int unsigned   CW       = largura(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    estado_tecla_t estado_q, estado_d;
    logic [CW-1:0] cont_q, cont_d;
    logic          pressionada;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            estado_q <= SOLTA;
            cont_q   <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            estado_q <= estado_d;
            cont_q   <= cont_d;
        end
    end

    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        pressionada = ~sync2_q;
        estado_d    = estado_q;
        cont_d      = '0;
        // Any cycle that agrees with the stable state restarts the count.
        if (pressionada != (estado_q == PRESSIONADA)) begin
            if (cont_q == CONT_MAX) begin
                estado_d = pressionada ? PRESSIONADA : SOLTA;
            end else begin
                cont_d = cont_q + 1'b1;
            end
        end
    end

    // Next-state view so the consumer's registers change on the same edge
    // as the stable state itself.
    assign nivel      = (estado_d == PRESSIONADA);
    assign pressionou = (estado_q == SOLTA) && (estado_d == PRESSIONADA);

endmodule

// File: rtl/controle_teclas.sv
// controle_teclas: input stage feeding the ship (nave) block.
//   Debounces the four board pushbuttons and turns them into rate-limited
//   single-cycle move pulses, a pause toggle and a restart pulse.
// Ports:
//   CLOCK_50      - system clock, 50 MHz
//   reset         - asynchronous active-low reset
//   KEY[3:0]      - raw pushbuttons, active-low: [0] right, [1] left,
//                   [2] pause, [3] restart
//   keysout[3:0]  - [0] right move pulse, [1] left move pulse,
//                   [2] debounced pause level, [3] debounced restart level
//   pausa         - pause state level
//   reiniciarJogo - single-cycle restart pulse
// Build option:
//   ACELERACAO_EN - when defined, a direction held for ACCEL_CYCLES repeats
//                   at TICK_CYCLES/2 instead of TICK_CYCLES.
module controle_teclas
    import teclas_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
    parameter int unsigned TICK_CYCLES     = TICK_PADRAO
`ifdef ACELERACAO_EN
    ,
    parameter int unsigned ACCEL_CYCLES    = ACCEL_PADRAO
`endif
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    output logic [3:0] keysout,
    output logic       pausa,
    output logic       reiniciarJogo
);

    localparam int unsigned   TW       = largura(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);
`ifdef ACELERACAO_EN
    localparam int unsigned   TICK_RAPIDO     = TICK_CYCLES / 2;
    localparam logic [TW-1:0] TICK_RAPIDO_MAX = TW'((TICK_RAPIDO > 0) ? TICK_RAPIDO - 1 : 0);
    localparam int unsigned   AW              = largura(ACCEL_CYCLES);
    localparam logic [AW-1:0] ACCEL_MAX       = AW'(ACCEL_CYCLES);
`endif

    logic [3:0] nivel;
    logic [3:0] press;

    for (genvar g = 0; g < 4; g++) begin : g_tecla
        debounce_tecla #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLOCK_50   (CLOCK_50),
            .reset      (reset),
            .key_n      (KEY[g]),
            .nivel      (nivel[g]),
            .pressionou (press[g])
        );
    end

    logic [1:0][TW-1:0] rep_q, rep_d;
    logic [1:0][TW-1:0] limite;
    logic [1:0]         pulso;
    logic [1:0]         mov_q, mov_d;
    logic [1:0]         comando_q, comando_d;
    logic               pausa_q, pausa_d;
    logic               reinicio_q, reinicio_d;
    logic               bloqueio;
`ifdef ACELERACAO_EN
    logic [1:0][AW-1:0] acel_q, acel_d;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            rep_q      <= '0;
            mov_q      <= '0;
            comando_q  <= '0;
            pausa_q    <= 1'b0;
            reinicio_q <= 1'b0;
`ifdef ACELERACAO_EN
            acel_q     <= '0;
`endif
        end else begin
            rep_q      <= rep_d;
            mov_q      <= mov_d;
            comando_q  <= comando_d;
            pausa_q    <= pausa_d;
            reinicio_q <= reinicio_d;
`ifdef ACELERACAO_EN
            acel_q     <= acel_d;
`endif
        end
    end

    always_comb begin
        comando_d  = {nivel[TECLA_REINICIO], nivel[TECLA_PAUSA]};
        reinicio_d = press[TECLA_REINICIO];
        pausa_d    = pausa_q ^ press[TECLA_PAUSA];
        // Restart overrides a simultaneous pause toggle.
        if (press[TECLA_REINICIO]) begin
            pausa_d = 1'b0;
        end

        // Using next-state levels means simultaneous presses of both
        // directions are already treated as both held.
        bloqueio = pausa_d | (nivel[TECLA_DIR] & nivel[TECLA_ESQ]);

        for (int unsigned i = 0; i < 2; i++) begin
            rep_d[i]  = '0;
            pulso[i]  = 1'b0;
            limite[i] = TICK_MAX;
`ifdef ACELERACAO_EN
            acel_d[i] = '0;
            if (nivel[i]) begin
                acel_d[i] = (acel_q[i] == ACCEL_MAX) ? acel_q[i] : acel_q[i] + 1'b1;
            end
            if (acel_q[i] == ACCEL_MAX) begin
                limite[i] = TICK_RAPIDO_MAX;
            end
`endif
            if (press[i]) begin
                pulso[i] = 1'b1;
            end else if (nivel[i]) begin
                // >= so a shortened period takes effect even mid-count.
                if (rep_q[i] >= limite[i]) begin
                    pulso[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
            // Counters keep running while blocked to preserve the cadence.
            mov_d[i] = pulso[i] & ~bloqueio;
        end
    end

    assign keysout       = {comando_q, mov_q};
    assign pausa         = pausa_q;
    assign reiniciarJogo = reinicio_q;

endmodule

// File: tb/tb_controle_teclas.sv
module tb_controle_teclas;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [3:0] KEY;
    logic [3:0] keysout;
    logic       pausa;
    logic       reiniciarJogo;
    logic [5:0] obs;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    controle_teclas #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (8)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .KEY           (KEY),
        .keysout       (keysout),
        .pausa         (pausa),
        .reiniciarJogo (reiniciarJogo)
    );

    // {reiniciarJogo, pausa, keysout[3:0]}
    assign obs = {reiniciarJogo, pausa, keysout};

    task automatic chk(input string tag, input logic [5:0] esperado);
        n_vec++;
        assert (obs === esperado) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, esperado);
        end
    endtask

    task automatic segura(input int unsigned n, input string tag, input logic [5:0] esperado);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge CLOCK_50);
            chk(tag, esperado);
        end
    endtask

    // Press and release the pause key starting from pausa = 0.
    task automatic liga_pausa();
        KEY = 4'b1011;
        segura(5, "liga_pausa_lat", 6'b000000);
        segura(1, "liga_pausa", 6'b010100);
        segura(2, "liga_pausa_tecla", 6'b010100);
        KEY = 4'b1111;
        segura(5, "liga_pausa_solta_lat", 6'b010100);
        segura(5, "liga_pausa_solta", 6'b010000);
    endtask

    initial begin
        // Reset with all keys held, then release reset: all four keys
        // debounce together; restart wins over pause, move pulses blocked.
        reset = 1'b0;
        KEY   = 4'b0000;
        segura(3, "reset_ativo", 6'b000000);
        reset = 1'b1;
        segura(5, "pos_reset_lat", 6'b000000);
        segura(1, "pos_reset_primeira", 6'b101100);
        segura(3, "pos_reset_tecla", 6'b001100);
        KEY = 4'b1111;
        segura(5, "pos_reset_solta_lat", 6'b001100);
        segura(6, "pos_reset_solta", 6'b000000);

        // Glitch of 3 cycles on the right key.
        KEY = 4'b1110;
        segura(3, "glitch", 6'b000000);
        KEY = 4'b1111;
        segura(10, "glitch_pos", 6'b000000);

        // Hold right for 40 cycles: pulses at 6, 14, 22, 30, 38.
        KEY = 4'b1110;
        for (int unsigned k = 1; k <= 40; k++) begin
            @(negedge CLOCK_50);
            chk("segura_dir", (k >= 6 && ((k - 6) % 8) == 0) ? 6'b000001 : 6'b000000);
        end
        KEY = 4'b1111;
        segura(12, "solta_dir", 6'b000000);

        // Both directions held, then left released at cycle 20.
        KEY = 4'b1100;
        segura(20, "ambas", 6'b000000);
        KEY = 4'b1110;
        for (int unsigned k = 21; k <= 38; k++) begin
            @(negedge CLOCK_50);
            chk("retoma_dir", (k == 30 || k == 38) ? 6'b000001 : 6'b000000);
        end
        KEY = 4'b1111;
        segura(12, "solta_ambas", 6'b000000);

        // Pause on, right held yields nothing, pause off.
        liga_pausa();
        KEY = 4'b1110;
        segura(24, "pausado_dir", 6'b010000);
        KEY = 4'b1111;
        segura(10, "pausado_solta", 6'b010000);
        KEY = 4'b1011;
        segura(5, "desliga_pausa_lat", 6'b010000);
        segura(1, "desliga_pausa", 6'b000100);
        segura(2, "desliga_pausa_tecla", 6'b000100);
        KEY = 4'b1111;
        segura(5, "desliga_solta_lat", 6'b000100);
        segura(5, "despausado", 6'b000000);

        // Restart while paused.
        liga_pausa();
        KEY = 4'b0111;
        segura(5, "reinicio_lat", 6'b010000);
        segura(1, "reinicio", 6'b101000);
        segura(3, "reinicio_tecla", 6'b001000);
        KEY = 4'b1111;
        segura(5, "reinicio_solta_lat", 6'b001000);
        segura(5, "reinicio_solto", 6'b000000);

        // Restart and pause pressed together while paused.
        liga_pausa();
        KEY = 4'b0011;
        segura(5, "reinicio_pausa_lat", 6'b010000);
        segura(1, "reinicio_pausa", 6'b101100);
        segura(3, "reinicio_pausa_tecla", 6'b001100);
        KEY = 4'b1111;
        segura(5, "reinicio_pausa_solta_lat", 6'b001100);
        segura(5, "reinicio_pausa_solto", 6'b000000);

        // Reset asserted mid-press; keys still held re-debounce afterwards.
        KEY = 4'b0110;
        segura(5, "pre_reset_lat", 6'b000000);
        segura(1, "pre_reset_press", 6'b101001);
        segura(3, "pre_reset_tecla", 6'b001000);
        reset = 1'b0;
        #1;
        chk("reset_assinc", 6'b000000);
        segura(2, "reset_meio", 6'b000000);
        reset = 1'b1;
        segura(5, "repress_lat", 6'b000000);
        segura(1, "repress", 6'b101001);
        segura(2, "repress_tecla", 6'b001000);
        KEY = 4'b1111;
        segura(5, "repress_solta_lat", 6'b001000);
        segura(4, "repress_solto", 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controle_teclas.md
Name: controle_teclas

Overview:
- Upstream input stage of the ship (nave) block.
- Conditions the four raw active-low board pushbuttons: synchronise, debounce, edge-detect.
- Produces `keysout[3:0]`, `pausa` and `reiniciarJogo` in the form the ship stage expects.
- The ship adds or subtracts 1 on every cycle a move bit is high, so this block emits rate-limited single-cycle move pulses rather than raw levels.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key change (10 ms at 50 MHz).
- TICK_CYCLES, 250000: cycles between repeated move pulses while a direction key is held.
- ACCEL_CYCLES, 25000000: hold time after which the repeat period halves (ACELERACAO_EN only).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset
- KEY  input  4  raw pushbuttons, active-low (0 = pressed); [0] right, [1] left, [2] pause, [3] restart
- keysout  output  4  [0] right move pulse, [1] left move pulse, [2] debounced pause-key level, [3] debounced restart-key level
- pausa  output  1  pause state level
- reiniciarJogo  output  1  single-cycle restart pulse

Behaviour:
- Reset (reset = 0, asynchronous):
  - Outputs: `keysout = 0`, `pausa = 0`, `reiniciarJogo = 0`.
  - Sync flops = 1 (released).
  - Debounced states = released.
  - All counters = 0.
- Synchronisation: each KEY bit passes two flops. `p[i] = ~sync2[i]` is the pressed indication.
- Debounce, per key:
  - Keep a stable state `s[i]` and a counter `c[i]`.
  - If `p[i] == s[i]`: `c[i] = 0`.
  - Otherwise `c[i]++`. When `c[i]` reaches DEBOUNCE_CYCLES-1, `s[i]` flips and `c[i] = 0`.
  - A single mismatch-free cycle restarts the count (glitch rejection).
- Edge detect: `press[i]` is high for one cycle on the cycle `s[i]` goes 0 to 1.
- Latency: raw edge to `s[i]` change = 2 sync cycles + DEBOUNCE_CYCLES.
- Move pulses (bits 0 and 1), one repeat counter per direction:
  - On `press[i]`, `keysout[i] = 1` for that cycle and the counter loads 0.
  - While `s[i]` stays held, the counter increments. At TICK_CYCLES-1 it emits a one-cycle pulse and wraps to 0.
  - On release the counter is cleared and no pulse is emitted.
  - Suppression: no move pulses while `pausa = 1`, or while `s[0]` and `s[1]` are both held. Counters keep running in these conditions so the cadence is preserved.
- `keysout[3:2] = s[3:2]` (registered levels).
- Pause: `press[2]` toggles `pausa`.
- Restart:
  - `press[3]` drives `reiniciarJogo = 1` for exactly one cycle and forces `pausa = 0` in the same cycle.
  - If `press[2]` and `press[3]` occur in the same cycle, restart wins: `pausa = 0`.
- All outputs are registered; no combinational path from KEY to any output.
- Reset mid-press: all state clears. A key still held after reset release must be re-debounced and then produces a fresh press edge.

Optional Feature:
- Macro: ACELERACAO_EN.
- Defined:
  - A per-direction hold counter saturates at ACCEL_CYCLES.
  - Once saturated, the repeat period becomes TICK_CYCLES/2 (integer divide).
  - The hold counter clears on release.
- Undefined: no hold counters are instantiated and the repeat period is always TICK_CYCLES.

Decomposition:
- Shared package `teclas_pkg` holds:
  - Key index constants: TECLA_DIR = 0, TECLA_ESQ = 1, TECLA_PAUSA = 2, TECLA_REINICIO = 3.
  - Default timing constants.
  - Helper function for counter width (clog2 of the parameters).
- Natural sub-module: `debounce_tecla`, a single-bit synchroniser + debouncer + rising-edge detector.
  - Ports: `CLOCK_50`, `reset`, `key_n`, `nivel`, `pressionou`.
  - Instantiated 4 times.
- Repeat, pause and restart logic live in the top level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4 and TICK_CYCLES = 8.
1. Reset:
   - Stimulus: assert `reset = 0` with KEY = 4'b0000 for 3 cycles, then release.
   - Required: `keysout = 0`, `pausa = 0`, `reiniciarJogo = 0` during and immediately after reset. First outputs appear after 2 + 4 cycles.
2. Glitch rejection:
   - Stimulus: KEY[0] low for 3 cycles, then high.
   - Required: `s[0]` never sets and `keysout[0]` stays 0.
3. Hold right:
   - Stimulus: KEY[0] low for 40 cycles.
   - Required: first `keysout[0]` pulse 6 cycles after the edge, then pulses every 8 cycles, each 1 cycle wide.
   - Release: pulses stop and none are emitted afterwards.
4. Both directions:
   - Stimulus: KEY[1:0] both held.
   - Required: `keysout[1:0]` stay 0.
   - Releasing KEY[1] resumes right pulses at the running cadence.
5. Pause:
   - Stimulus: press and release KEY[2].
   - Required: `pausa` goes 1; KEY[0] held yields no pulses.
   - Second press: `pausa` returns to 0.
6. Restart:
   - Stimulus: with `pausa = 1`, press KEY[3] (simultaneously with KEY[2] in a second run).
   - Required: `reiniciarJogo` is high for exactly 1 cycle, `pausa` = 0 on that cycle, and `keysout[3]` is high while held.
